// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states, opcode/funct codes,
// ALU and load-type encodings, and the instruction-class bundle from decode to the FSM.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MULDIV = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic alu;
        logic branch;
        logic jump;
        logic link;
        logic load;
        logic store;
        logic muldiv;
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI    = 6'h0d, OP_XORI = 6'h0e, OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH     = 6'h21, OP_LWL  = 6'h22, OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU    = 6'h25, OP_LWR  = 6'h26;
    localparam logic [5:0] OP_SB    = 6'h28, OP_SH     = 6'h29, OP_SW   = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MFLO = 6'h12, FN_MULT  = 6'h18, FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV  = 6'h1a, FN_DIVU = 6'h1b, FN_ADD   = 6'h20, FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2a, FN_SLTU  = 6'h2b;

    localparam int ALU_OP_W = 5;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0,  ALU_SUB   = 5'd1,  ALU_AND  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd3,  ALU_XOR   = 5'd4,  ALU_NOR  = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd6,  ALU_SLTU  = 5'd7,  ALU_SLL  = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd9,  ALU_SRA   = 5'd10, ALU_SLLV = 5'd11;
    localparam logic [ALU_OP_W-1:0] ALU_SRLV = 5'd12, ALU_SRAV  = 5'd13, ALU_LUI  = 5'd14;
    localparam logic [ALU_OP_W-1:0] ALU_MFHI = 5'd15, ALU_MFLO  = 5'd16, ALU_MULT = 5'd17;
    localparam logic [ALU_OP_W-1:0] ALU_MULTU = 5'd18, ALU_DIV  = 5'd19, ALU_DIVU = 5'd20;
    localparam logic [ALU_OP_W-1:0] ALU_BEQ  = 5'd21, ALU_BNE   = 5'd22, ALU_BLEZ = 5'd23;
    localparam logic [ALU_OP_W-1:0] ALU_BGTZ = 5'd24, ALU_BLTZ  = 5'd25, ALU_BGEZ = 5'd26;

    localparam logic [2:0] LD_W = 3'd0, LD_B = 3'd1, LD_BU = 3'd2, LD_H = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4, LD_WL = 3'd5, LD_WR = 3'd6;

endpackage

// File: rtl/mc_decode.sv
// Instruction decode: op/funct/rt -> datapath selects and instruction class.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow the IR fields directly.
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic [4:0]          dest,
    output iclass_t             cls,
    output logic                alusrc,
    output logic                regdst1,
    output logic                regdst2,
    output logic                memtoreg1,
    output logic                memtoreg2,
    output logic                jump,
    output logic                jump1,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          loadcontrol
);

    always_comb begin
        cls         = '0;
        alusrc      = 1'b0;
        regdst1     = 1'b0;
        regdst2     = 1'b0;
        memtoreg1   = 1'b0;
        memtoreg2   = 1'b0;
        jump        = 1'b0;
        jump1       = 1'b0;
        alu_op      = ALU_ADD;
        loadcontrol = LD_W;
        case (op)
            OP_RTYPE: begin
                regdst1 = 1'b1;
                cls.alu = 1'b1;
                case (funct)
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    FN_SLLV:         alu_op = ALU_SLLV;
                    FN_SRLV:         alu_op = ALU_SRLV;
                    FN_SRAV:         alu_op = ALU_SRAV;
                    FN_MFHI:         alu_op = ALU_MFHI;
                    FN_MFLO:         alu_op = ALU_MFLO;
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_JR: begin
                        cls   = '0;
                        cls.jump = 1'b1;
                        jump  = 1'b1;
                        jump1 = 1'b1;
                    end
                    FN_JALR: begin
                        cls       = '0;
                        cls.link  = 1'b1;
                        jump      = 1'b1;
                        jump1     = 1'b1;
                        memtoreg2 = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        cls        = '0;
                        cls.muldiv = 1'b1;
                        alu_op     = ALU_MULT + ALU_OP_W'(funct[1:0]);
                    end
                    default: cls = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                cls.alu = 1'b1;
                alusrc  = 1'b1;
                case (op)
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    OP_ANDI:  alu_op = ALU_AND;
                    OP_ORI:   alu_op = ALU_OR;
                    OP_XORI:  alu_op = ALU_XOR;
                    OP_LUI:   alu_op = ALU_LUI;
                    default:  alu_op = ALU_ADD;
                endcase
            end
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
                cls.load  = 1'b1;
                alusrc    = 1'b1;
                memtoreg1 = 1'b1;
                case (op)
                    OP_LB:   loadcontrol = LD_B;
                    OP_LBU:  loadcontrol = LD_BU;
                    OP_LH:   loadcontrol = LD_H;
                    OP_LHU:  loadcontrol = LD_HU;
                    OP_LWL:  loadcontrol = LD_WL;
                    OP_LWR:  loadcontrol = LD_WR;
                    default: loadcontrol = LD_W;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                cls.store = 1'b1;
                alusrc    = 1'b1;
            end
            OP_BEQ:  begin cls.branch = 1'b1; alu_op = ALU_BEQ;  end
            OP_BNE:  begin cls.branch = 1'b1; alu_op = ALU_BNE;  end
            OP_BLEZ: begin cls.branch = 1'b1; alu_op = ALU_BLEZ; end
            OP_BGTZ: begin cls.branch = 1'b1; alu_op = ALU_BGTZ; end
            OP_REGIMM: begin
                // rt picks bltz/bgez (and their -al forms, whose link is not taken here)
                if (dest[3:1] == 3'b000) begin
                    cls.branch = 1'b1;
                    alu_op     = dest[0] ? ALU_BGEZ : ALU_BLTZ;
                end
            end
            OP_J: begin
                cls.jump = 1'b1;
                jump     = 1'b1;
            end
            OP_JAL: begin
                cls.link  = 1'b1;
                jump      = 1'b1;
                regdst2   = 1'b1;
                memtoreg2 = 1'b1;
            end
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: fetch/decode/exec/(muldiv|mem)/wb sequencing and datapath enables.
// Latency: ALU 4, load 5, store 4, branch/jump 3, mult/div 2+MULDIV_CYCLES cycles (no wait states).
// Backpressure: FETCH and MEM hold with strobes stable while waitrequest is high.
module mc_controller
    import mips_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int ALU_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [4:0]       dest,
    input  logic             zero,
    input  logic             waitrequest,
    input  logic             pc_next_zero,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             regwrite,
    output logic             alusrc,
    output logic             regdst1,
    output logic             regdst2,
    output logic             memtoreg1,
    output logic             memtoreg2,
    output logic             jump,
    output logic             jump1,
    output logic [ALU_W-1:0] alucontrol,
    output logic [2:0]       loadcontrol,
    output logic             hi_lo_write,
    output logic             active,
    output logic [2:0]       state_o
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 halt_pend_q, halt_pend_d;
    iclass_t              cls;
    logic                 dec_alusrc, dec_regdst1, dec_regdst2, dec_memtoreg1, dec_memtoreg2;
    logic                 dec_jump, dec_jump1;
    logic [ALU_OP_W-1:0]  dec_alu_op;
    logic [2:0]           dec_loadcontrol;
    logic                 sel_en;

    mc_decode u_decode (
        .op          (op),
        .funct       (funct),
        .dest        (dest),
        .cls         (cls),
        .alusrc      (dec_alusrc),
        .regdst1     (dec_regdst1),
        .regdst2     (dec_regdst2),
        .memtoreg1   (dec_memtoreg1),
        .memtoreg2   (dec_memtoreg2),
        .jump        (dec_jump),
        .jump1       (dec_jump1),
        .alu_op      (dec_alu_op),
        .loadcontrol (dec_loadcontrol)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        regwrite    = 1'b0;
        hi_lo_write = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (!waitrequest) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: state_d = cls.muldiv ? ST_MULDIV : ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (cls.branch) begin
                    pc_write = zero;
                end else if (cls.jump) begin
                    pc_write = 1'b1;
                end else if (cls.link) begin
                    // link write still happens; a zero PC halts only after WB
                    pc_write    = 1'b1;
                    halt_pend_d = pc_next_zero;
                    state_d     = ST_WB;
                end else if (cls.load || cls.store) begin
                    state_d = ST_MEM;
                end else if (cls.alu) begin
                    state_d = ST_WB;
                end
            end
            ST_MULDIV: begin
                if (cnt_q == CNT_LAST) begin
                    hi_lo_write = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEM: begin
                mem_read  = cls.load;
                mem_write = cls.store;
                if (!waitrequest) begin
                    state_d = cls.load ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                regwrite    = 1'b1;
                halt_pend_d = 1'b0;
                state_d     = halt_pend_q ? ST_HALT : ST_FETCH;
            end
            default: state_d = ST_HALT;
        endcase
        if (pc_write && pc_next_zero && (state_d != ST_WB)) begin
            state_d = ST_HALT;
        end
    end

    // selects are only meaningful while an instruction is in flight past fetch
    assign sel_en      = (state_q != ST_FETCH) && (state_q != ST_HALT);
    assign alusrc      = sel_en & dec_alusrc;
    assign regdst1     = sel_en & dec_regdst1;
    assign regdst2     = sel_en & dec_regdst2;
    assign memtoreg1   = sel_en & dec_memtoreg1;
    assign memtoreg2   = sel_en & dec_memtoreg2;
    assign jump        = sel_en & dec_jump;
    assign jump1       = sel_en & dec_jump1;
    assign alucontrol  = sel_en ? ALU_W'(dec_alu_op) : '0;
    assign loadcontrol = sel_en ? dec_loadcontrol : LD_W;
    assign active      = (state_q != ST_HALT);
    assign state_o     = state_q;

endmodule
